fetch_stage: RTL and testbench

//  IF stage of the 5-stage RISC pipeline; directly upstream of the decode control FSM.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fetch_stage_pc_select.sv | 53 +++++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the RISC pipeline front end.
//   NOP_INSTR          : encoding inserted into IF/ID for bubbles and flushes
//   OPCODE_LDM         : major opcode of the two-word load-immediate instruction
//   RESET_VEC_HI_ADDR  : imem word holding PC[31:16] at boot
//   RESET_VEC_LO_ADDR  : imem word holding PC[15:0] at boot
//   fetch_state_t      : boot/run sequencing of the fetch stage
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR  = 16'h4000;
  localparam logic [4:0]  OPCODE_LDM = 5'b10001;

  localparam int unsigned RESET_VEC_HI_ADDR = 32'd0;
  localparam int unsigned RESET_VEC_LO_ADDR = 32'd1;

  typedef enum logic [1:0] {
    BOOT_HI = 2'd0,
    BOOT_LO = 2'd1,
    RUN     = 2'd2
  } fetch_state_t;

  // True when an instruction word carries the LDM major opcode.
  function automatic logic is_ldm(input logic [15:0] instr);
    return (instr[15:11] == OPCODE_LDM);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_select.sv
// -----------------------------------------------------------------------------
// pc_select
// Combinational next-PC priority mux for the fetch stage while running.
// Priority (highest first): memory PC, taken jump, stall, sequential step.
// Ports:
//   pc_i               current PC
//   pc_write_i         0 = stall (hold PC and IF/ID)
//   jump_taken_i       branch resolved taken
//   jump_target_i      jump destination
//   pc_choose_memory_i load PC from memory stage (RET/RETI/interrupt)
//   mem_pc_i           PC value from memory stage
//   pc_next_o          PC to load on the next edge
//   flush_o            IF/ID must be replaced by a NOP bubble
//   hold_o             PC and IF/ID keep their values
// -----------------------------------------------------------------------------
module pc_select
  import cpu_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            pc_write_i,
  input  logic            jump_taken_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            pc_choose_memory_i,
  input  logic [PC_W-1:0] mem_pc_i,
  output logic [PC_W-1:0] pc_next_o,
  output logic            flush_o,
  output logic            hold_o
);

  // Priority decode: a redirect always wins over a stall so that control
  // transfers are never lost while decode is holding the pipe.
  always_comb begin
    pc_next_o = pc_i;
    flush_o   = 1'b0;
    hold_o    = 1'b0;
    if (pc_choose_memory_i) begin
      pc_next_o = mem_pc_i;
      flush_o   = 1'b1;
    end else if (jump_taken_i) begin
      pc_next_o = jump_target_i;
      flush_o   = 1'b1;
    end else if (!pc_write_i) begin
      pc_next_o = pc_i;
      hold_o    = 1'b1;
    end else begin
      // Natural modulo-2^PC_W wrap at the top of the address space.
      pc_next_o = pc_i + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// IF stage of the 5-stage RISC pipeline. Boots the PC from imem words 0/1,
// then steps the PC, honouring stall, bubble, jump and memory-PC controls,
// and produces the IF/ID pipeline register.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   imem_addr/rdata     combinational instruction memory read port
//   pc_write            0 = stall
//   clear_instruction   bubble; fetched word is captured into ifid_imm
//   jump_taken/target   EX-resolved branch redirect
//   pc_choose_memory    load PC from mem_pc (RET/RETI/interrupt)
//   pc                  current PC
//   ifid_instr/imm/pc/valid  IF/ID register contents
// The PC is assumed to be 32 bits wide: the boot vector fills it as two
// 16-bit halves.
// -----------------------------------------------------------------------------
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int IMEM_AW = 20,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_rdata,
  input  logic               pc_write,
  input  logic               clear_instruction,
  input  logic               jump_taken,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               pc_choose_memory,
  input  logic [PC_W-1:0]    mem_pc,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        ifid_instr,
  output logic [15:0]        ifid_imm,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     imm_q, imm_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic            valid_q, valid_d;

  logic [PC_W-1:0] pc_next_s;
  logic            flush_s;
  logic            hold_s;

  pc_select #(
    .PC_W (PC_W)
  ) u_pc_select (
    .pc_i               (pc_q),
    .pc_write_i         (pc_write),
    .jump_taken_i       (jump_taken),
    .jump_target_i      (jump_target),
    .pc_choose_memory_i (pc_choose_memory),
    .mem_pc_i           (mem_pc),
    .pc_next_o          (pc_next_s),
    .flush_o            (flush_s),
    .hold_o             (hold_s)
  );

  // Next-state, next-PC and IF/ID load decode.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    imem_addr = IMEM_AW'(RESET_VEC_HI_ADDR);
    case (state_q)
      BOOT_HI: begin
        imem_addr       = IMEM_AW'(RESET_VEC_HI_ADDR);
        pc_d[PC_W-1 -: 16] = imem_rdata;
        state_d         = BOOT_LO;
      end
      BOOT_LO: begin
        imem_addr = IMEM_AW'(RESET_VEC_LO_ADDR);
        pc_d[15:0] = imem_rdata;
        state_d   = RUN;
      end
      RUN: begin
        // Upper PC bits are kept architecturally but do not address memory.
        imem_addr = pc_q[IMEM_AW-1:0];
        if (flush_s) begin
          pc_d    = pc_next_s;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (hold_s) begin
          pc_d = pc_q;
        end else begin
          pc_d      = pc_next_s;
          ifid_pc_d = pc_next_s;
          if (clear_instruction) begin
            // Second word of LDM: keep it as data, bubble the decode slot.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            imm_d   = imem_rdata;
          end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = BOOT_HI;
      end
    endcase
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BOOT_HI;
      pc_q      <= '0;
      instr_q   <= NOP_INSTR;
      imm_q     <= 16'h0000;
      ifid_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
    end
  end

  assign pc         = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_imm   = imm_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int IMEM_AW = 20;
  localparam int PC_W    = 32;

  logic               clk;
  logic               reset;
  logic [IMEM_AW-1:0] imem_addr;
  logic [15:0]        imem_rdata;
  logic               pc_write;
  logic               clear_instruction;
  logic               jump_taken;
  logic [PC_W-1:0]    jump_target;
  logic               pc_choose_memory;
  logic [PC_W-1:0]    mem_pc;
  logic [PC_W-1:0]    pc;
  logic [15:0]        ifid_instr;
  logic [15:0]        ifid_imm;
  logic [PC_W-1:0]    ifid_pc;
  logic               ifid_valid;

  logic [15:0] imem [0:1023];
  int checks;
  int errors;

  assign imem_rdata = imem[imem_addr[9:0]];

  fetch_stage #(.IMEM_AW(IMEM_AW), .PC_W(PC_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .pc_write          (pc_write),
    .clear_instruction (clear_instruction),
    .jump_taken        (jump_taken),
    .jump_target       (jump_target),
    .pc_choose_memory  (pc_choose_memory),
    .mem_pc            (mem_pc),
    .pc                (pc),
    .ifid_instr        (ifid_instr),
    .ifid_imm          (ifid_imm),
    .ifid_pc           (ifid_pc),
    .ifid_valid        (ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] ins, input logic v,
                          input logic [31:0] ipc, input logic [15:0] imm);
    chk({tag, "_instr"}, {16'h0000, ifid_instr}, {16'h0000, ins});
    chk({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, v});
    chk({tag, "_ifidpc"}, ifid_pc, ipc);
    chk({tag, "_imm"}, {16'h0000, ifid_imm}, {16'h0000, imm});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) imem[i] = 16'h1000 + 16'(i);
    imem[0]    = 16'h0000;
    imem[1]    = 16'h0020;
    imem[10'h40] = 16'h8800;
    imem[10'h41] = 16'h1234;

    reset = 1'b1; pc_write = 1'b1; clear_instruction = 1'b0;
    jump_taken = 1'b0; jump_target = 32'h0; pc_choose_memory = 1'b0; mem_pc = 32'h0;
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", {12'h000, imem_addr}, 32'h0);
    chk_ifid("rst", 16'h4000, 1'b0, 32'h0, 16'h0000);

    // Boot: controls asserted during boot must be ignored.
    reset = 1'b0; pc_write = 1'b0; jump_taken = 1'b1; jump_target = 32'h0000_0777;
    step();
    chk("boot1_addr", {12'h000, imem_addr}, 32'h1);
    chk("boot1_pc", pc, 32'h0);
    step();
    chk("boot2_pc", pc, 32'h20);
    chk("boot2_addr", {12'h000, imem_addr}, 32'h20);
    chk_ifid("boot2", 16'h4000, 1'b0, 32'h0, 16'h0000);
    pc_write = 1'b1; jump_taken = 1'b0;
    step();
    chk("run1_pc", pc, 32'h21);
    chk_ifid("run1", 16'h1020, 1'b1, 32'h21, 16'h0000);

    // Jump to 0x2F: flushed slot, ifid_pc holds.
    jump_taken = 1'b1; jump_target = 32'h2F;
    step();
    chk("jmp2f_pc", pc, 32'h2F);
    chk_ifid("jmp2f", 16'h4000, 1'b0, 32'h21, 16'h0000);
    jump_taken = 1'b0;
    step();
    chk("seq30_pc", pc, 32'h30);
    chk_ifid("seq30", 16'h102F, 1'b1, 32'h30, 16'h0000);

    // Stall three cycles at pc=0x30.
    pc_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", pc, 32'h30);
      chk_ifid("stall", 16'h102F, 1'b1, 32'h30, 16'h0000);
    end
    pc_write = 1'b1;
    step();
    chk("resume_pc", pc, 32'h31);
    chk_ifid("resume", 16'h1030, 1'b1, 32'h31, 16'h0000);

    // LDM at 0x40 with its immediate at 0x41.
    jump_taken = 1'b1; jump_target = 32'h40;
    step();
    jump_taken = 1'b0;
    step();
    chk("ldm_op_pc", pc, 32'h41);
    chk_ifid("ldm_op", 16'h8800, 1'b1, 32'h41, 16'h0000);
    clear_instruction = 1'b1;
    step();
    clear_instruction = 1'b0;
    chk("ldm_imm_pc", pc, 32'h42);
    chk_ifid("ldm_imm", 16'h4000, 1'b0, 32'h42, 16'h1234);

    // Memory PC beats jump.
    jump_taken = 1'b1; jump_target = 32'h100; pc_choose_memory = 1'b1; mem_pc = 32'h200;
    step();
    jump_taken = 1'b0; pc_choose_memory = 1'b0;
    chk("mempc_pc", pc, 32'h200);
    chk_ifid("mempc", 16'h4000, 1'b0, 32'h42, 16'h1234);
    step();
    chk("seq201_pc", pc, 32'h201);
    chk_ifid("seq201", 16'h1200, 1'b1, 32'h201, 16'h1234);
    jump_taken = 1'b1; jump_target = 32'h100;
    step();
    jump_taken = 1'b0;
    chk("jmp100_pc", pc, 32'h100);
    chk_ifid("jmp100", 16'h4000, 1'b0, 32'h201, 16'h1234);
    step();
    chk("seq101_pc", pc, 32'h101);

    // Flush beats stall and bubble; ifid_imm untouched.
    jump_taken = 1'b1; jump_target = 32'h180; pc_write = 1'b0; clear_instruction = 1'b1;
    step();
    jump_taken = 1'b0; pc_write = 1'b1; clear_instruction = 1'b0;
    chk("flushwin_pc", pc, 32'h180);
    chk_ifid("flushwin", 16'h4000, 1'b0, 32'h101, 16'h1234);

    // Wrap at the top of the address space.
    jump_taken = 1'b1; jump_target = 32'hFFFF_FFFF;
    step();
    jump_taken = 1'b0;
    chk("top_pc", pc, 32'hFFFF_FFFF);
    chk("top_addr", {12'h000, imem_addr}, 32'h000F_FFFF);
    step();
    chk("wrap_pc", pc, 32'h0);
    chk_ifid("wrap", 16'h13FF, 1'b1, 32'h0, 16'h1234);

    // Reset mid-run at pc=0x55, with a jump pending that must be ignored.
    jump_taken = 1'b1; jump_target = 32'h55;
    step();
    chk("pre_rst_pc", pc, 32'h55);
    reset = 1'b1; jump_target = 32'h99;
    step();
    reset = 1'b0; jump_taken = 1'b0;
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_addr", {12'h000, imem_addr}, 32'h0);
    chk_ifid("mrst", 16'h4000, 1'b0, 32'h0, 16'h0000);
    step();
    step();
    chk("reboot_pc", pc, 32'h20);
    step();
    chk("reboot_run_pc", pc, 32'h21);
    chk_ifid("reboot_run", 16'h1020, 1'b1, 32'h21, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
